taho_impuls_sched: RTL and testbench
====================================

Name: taho_impuls_sched

Overview:
Readout scheduler for the tacho/impulse measurement datapath (freq1, freq2, imp words from the TAHO/IMPULS counters).
- On each second strobe it snapshots the three 16-bit results.
- It serialises the enabled words onto one shared 16-bit valid/ready stream toward the host frame builder.
- It tags each word with a channel id, times out a stalled consumer, and reports drops and overruns.

Parameters:
TIMEOUT_MS, 16'd500, msec ticks a word may sit unaccepted before the frame is dropped
CH_EN_RST, 3'b111, reset value of internal channel-enable register

Ports:
clock  in  1  system clock (clk_1MHz domain)
reset  in  1  asynchronous, active-low reset
sec  in  1  1-cycle second strobe, starts a frame
msec  in  1  1-cycle millisecond strobe, timeout timebase
cfg_we  in  1  write strobe for channel enable
cfg_ch_en  in  3  bit0=freq1, bit1=freq2, bit2=imp
freq1  in  16  tacho 1 result
freq2  in  16  tacho 2 result
imp  in  16  impulse result
out_data  out  16  stream word
out_id  out  2  0=freq1, 1=freq2, 2=imp, 3=checksum
out_valid  out  1  word valid
out_ready  in  1  consumer accepts
out_last  out  1  final word of frame
busy  out  1  frame in progress
overrun  out  1  sticky, sec arrived while busy
overrun_clr  in  1  clears overrun
drop_cnt  out  8  saturating count of timed-out frames

Behaviour:
- Reset (reset=0, async):
  - state IDLE; out_valid=0, out_last=0, busy=0, overrun=0, drop_cnt=0, out_data=0, out_id=0.
  - ch_en=CH_EN_RST; snapshots=0; timeout counter=0.
- ch_en register:
  - Loaded from cfg_ch_en when cfg_we=1, any state.
  - Sampled only in CAPTURE; a write mid-frame affects the next frame only.
- FSM states: IDLE, CAPTURE, SEND, DONE.
- IDLE:
  - sec=1 and ch_en!=0 -> CAPTURE.
  - sec=1 and ch_en==0 -> stay IDLE; no output, no overrun.
- CAPTURE, one cycle:
  - Latch freq1/freq2/imp into snapshot registers.
  - Latch the enabled mask; select the lowest enabled id; clear timeout counter.
  - Go to SEND.
  - busy=1 from CAPTURE through DONE.
- SEND:
  - out_valid=1; out_data/out_id driven from the snapshot of the selected id, held stable while out_ready=0.
  - out_last=1 when no higher enabled id remains.
  - Handshake when out_valid&out_ready:
    - Advance to the next enabled id in ascending order, or go to DONE if the word had out_last.
    - Clear the timeout counter.
    - out_valid stays high across back-to-back words; one word per cycle is possible.
- Timeout: in SEND, each msec tick without a handshake increments the counter.
  - On reaching TIMEOUT_MS: deassert out_valid next cycle, drop the remainder of the frame, drop_cnt+=1 (saturate at 255), go to DONE.
  - A handshake in the same cycle as the terminal tick wins: no drop.
- DONE, one cycle: out_valid=0, out_last=0, busy=0 next cycle, go to IDLE. A sec seen in DONE counts as overrun.
- Latency: sec at cycle N -> CAPTURE at N+1 -> first out_valid at N+2.
- Overrun:
  - sec while state!=IDLE sets overrun; that sec is otherwise ignored and the current frame continues unchanged.
  - overrun_clr clears it; simultaneous set and clear -> set wins.
- Snapshot isolation: changes on freq1/freq2/imp after CAPTURE never alter words of the current frame.
- Reset mid-frame: immediate return to reset values; a partially sent frame is abandoned with no last word.

Optional Feature:
TAHO_SCHED_CHKSUM_EN
- Defined:
  - After the last enabled data word, SEND emits one extra word, out_id=3.
  - out_data = sum mod 2^16 of the frame's data words.
  - out_last moves to this word.
  - The checksum word obeys the same handshake and timeout rules.
- Undefined: no checksum word, out_id never 3, and the sum logic is absent.

Test Plan:
1. ch_en=111, freq1=0x1234, freq2=0x0ABC, imp=0x0007, sec pulse, out_ready=1 -> at N+2..N+4 words (id0,0x1234),(id1,0x0ABC),(id2,0x0007,last); with CHKSUM_EN a fifth cycle adds (id3,0x1CF7,last); busy low after DONE.
2. ch_en=101, out_ready toggling 0/1 each cycle, inputs changed after CAPTURE -> ids 0 then 2 only, data equal to the captured values, out_data stable while out_ready=0.
3. out_ready=0 constantly, TIMEOUT_MS=3, msec every 10 cycles -> out_valid drops after the 3rd msec tick, drop_cnt=1; repeat 300 frames -> drop_cnt saturates at 255.
4. Second sec pulse mid-frame, then overrun_clr coincident with a third mid-frame sec -> the first frame completes intact, overrun=1 and remains 1 after the coincident clear; a later lone overrun_clr -> 0.
5. cfg_we writing 000 during SEND, then sec pulses -> the current frame finishes; later sec pulses produce no output and no overrun.
6. reset asserted during SEND at the second word -> out_valid=0 immediately, drop_cnt=0, ch_en=CH_EN_RST; the next sec produces a full fresh frame.

Source files
------------

// File: rtl/taho_impuls_sched.sv
// Tacho/impulse readout scheduler: snapshots freq1/freq2/imp on each second strobe and
// serialises the enabled words onto one tagged valid/ready stream. Optional checksum word: TAHO_SCHED_CHKSUM_EN.
module taho_impuls_sched #(
    parameter logic [15:0] TIMEOUT_MS = 16'd500,
    parameter logic [2:0]  CH_EN_RST  = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sec,
    input  logic        msec,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_ch_en,
    input  logic [15:0] freq1,
    input  logic [15:0] freq2,
    input  logic [15:0] imp,
    output logic [15:0] out_data,
    output logic [1:0]  out_id,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ch_en;
    logic [2:0]  mask;
    logic [15:0] snap_f1;
    logic [15:0] snap_f2;
    logic [15:0] snap_imp;
    logic [1:0]  cur_id;
    logic [1:0]  id_nxt;
    logic [1:0]  first_id;
    logic [1:0]  next_data_id;
    logic [1:0]  adv_id;
    logic [15:0] tcnt;
    logic [15:0] tcnt_nxt;
    logic        higher;
    logic        hs;
    logic        tick_expire;
    logic        drop_evt;
    logic [15:0] word_mux;

    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign hs        = out_valid && out_ready;

    // Channel order is fixed ascending; mask is the frame's frozen copy of ch_en.
    always_comb begin
        first_id = 2'd2;
        if (ch_en[0]) begin
            first_id = 2'd0;
        end else if (ch_en[1]) begin
            first_id = 2'd1;
        end
    end

    always_comb begin
        higher = 1'b0;
        case (cur_id)
            2'd0:    higher = mask[1] || mask[2];
            2'd1:    higher = mask[2];
            default: higher = 1'b0;
        endcase
        next_data_id = ((cur_id == 2'd0) && mask[1]) ? 2'd1 : 2'd2;
    end

    assign tick_expire = msec && (({1'b0, tcnt} + 17'd1) >= {1'b0, TIMEOUT_MS});

`ifdef TAHO_SCHED_CHKSUM_EN
    logic [15:0] chk_sum;

    always_comb begin
        chk_sum = (mask[0] ? snap_f1 : 16'd0)
                + (mask[1] ? snap_f2 : 16'd0)
                + (mask[2] ? snap_imp : 16'd0);
    end

    assign out_last = out_valid && (cur_id == 2'd3);
    assign adv_id   = higher ? next_data_id : 2'd3;
`else
    assign out_last = out_valid && !higher;
    assign adv_id   = next_data_id;
`endif

    always_comb begin
        word_mux = 16'd0;
        case (cur_id)
            2'd0:    word_mux = snap_f1;
            2'd1:    word_mux = snap_f2;
            2'd2:    word_mux = snap_imp;
`ifdef TAHO_SCHED_CHKSUM_EN
            default: word_mux = chk_sum;
`else
            default: word_mux = 16'd0;
`endif
        endcase
    end

    assign out_data = out_valid ? word_mux : 16'd0;
    assign out_id   = out_valid ? cur_id : 2'd0;

    // A handshake in the same cycle as the terminal msec tick takes priority over the drop.
    always_comb begin
        state_nxt = state;
        id_nxt    = cur_id;
        tcnt_nxt  = tcnt;
        drop_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (sec && (ch_en != 3'b000)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                id_nxt    = first_id;
                tcnt_nxt  = 16'd0;
                state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
                    tcnt_nxt = 16'd0;
                    if (out_last) begin
                        state_nxt = DONE;
                    end else begin
                        id_nxt = adv_id;
                    end
                end else if (tick_expire) begin
                    drop_evt  = 1'b1;
                    state_nxt = DONE;
                end else if (msec) begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch_en    <= CH_EN_RST;
            mask     <= 3'b000;
            snap_f1  <= 16'd0;
            snap_f2  <= 16'd0;
            snap_imp <= 16'd0;
            cur_id   <= 2'd0;
            tcnt     <= 16'd0;
        end else begin
            if (cfg_we) begin
                ch_en <= cfg_ch_en;
            end
            if (state == CAPTURE) begin
                mask     <= ch_en;
                snap_f1  <= freq1;
                snap_f2  <= freq2;
                snap_imp <= imp;
            end
            cur_id <= id_nxt;
            tcnt   <= tcnt_nxt;
        end
    end

    // Overrun set beats a coincident clear so no lost strobe goes unreported.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (sec && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (drop_evt && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_taho_impuls_sched.sv
// Scoreboard bench for taho_impuls_sched: a frame-level model queues expected words,
// a negedge monitor pops and compares them at every accepted handshake.
module tb_taho_impuls_sched;

    localparam logic [15:0] TMO    = 16'd3;
    localparam logic [2:0]  EN_RST = 3'b111;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  id;
        logic        last;
    } word_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sec = 1'b0;
    logic        msec = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch_en = 3'b000;
    logic [15:0] freq1 = 16'd0;
    logic [15:0] freq2 = 16'd0;
    logic [15:0] imp = 16'd0;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic [7:0]  drop_cnt;

    int    checks = 0;
    int    failures = 0;
    int    ready_mode = 3;
    int    model_drop = 0;
    logic [2:0] model_ch_en = EN_RST;
    word_t exp_q[$];

    taho_impuls_sched #(
        .TIMEOUT_MS(TMO),
        .CH_EN_RST (EN_RST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sec        (sec),
        .msec       (msec),
        .cfg_we     (cfg_we),
        .cfg_ch_en  (cfg_ch_en),
        .freq1      (freq1),
        .freq2      (freq2),
        .imp        (imp),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Frame model: enabled words in ascending id order, last on the final one (or the checksum).
    task automatic push_frame(input logic [2:0] en, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c);
        logic [15:0] vals[3];
        logic [15:0] sum;
        int hi;
        word_t w;
        vals[0] = a;
        vals[1] = b;
        vals[2] = c;
        sum = 16'd0;
        hi = en[2] ? 2 : (en[1] ? 1 : 0);
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                w.data = vals[i];
                w.id   = 2'(i);
`ifdef TAHO_SCHED_CHKSUM_EN
                w.last = 1'b0;
`else
                w.last = (i == hi);
`endif
                sum = sum + vals[i];
                exp_q.push_back(w);
            end
        end
`ifdef TAHO_SCHED_CHKSUM_EN
        w.data = sum;
        w.id   = 2'd3;
        w.last = 1'b1;
        exp_q.push_back(w);
`endif
    endtask

    task automatic apply_cfg(input logic [2:0] v);
        cfg_we    = 1'b1;
        cfg_ch_en = v;
        cycle();
        cfg_we      = 1'b0;
        model_ch_en = v;
    endtask

    // Returns in the first SEND cycle; input values change there to probe snapshot isolation.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                  input bit push, input bit chk_lat);
        freq1 = a;
        freq2 = b;
        imp   = c;
        sec   = 1'b1;
        cycle();
        sec = 1'b0;
        if (push) push_frame(model_ch_en, a, b, c);
        if (chk_lat) begin
            check_output("capture_busy", 32'(busy), 32'd1);
            check_output("capture_no_valid", 32'(out_valid), 32'd0);
        end
        cycle();
        if (chk_lat) check_output("first_valid_n2", 32'(out_valid), 32'd1);
        freq1 = 16'($urandom);
        freq2 = 16'($urandom);
        imp   = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            cycle();
        end
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
        check_output({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [31:0] sat_drop();
        return (model_drop > 255) ? 32'd255 : 32'(model_drop);
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom);
                3: out_ready = 1'b0;
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word actual=id%0d/0x%0h required=no word", out_id, out_data);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check_output("word_data", 32'(out_data), 32'(w.data));
                check_output("word_id", 32'(out_id), 32'(w.id));
                check_output("word_last", 32'(out_last), 32'(w.last));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tick;
        logic [2:0] en;
        cycle();
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_last", 32'(out_last), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        check_output("rst_drop", 32'(drop_cnt), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        check_output("rst_id", 32'(out_id), 32'd0);
        reset = 1'b1;
        cycle();

        $display("[TB] basic three-word frame");
        ready_mode = 0;
        apply_cfg(3'b111);
        apply_stimulus(16'h1234, 16'h0ABC, 16'h0007, 1, 1);
        wait_idle("basic");

        $display("[TB] mask 101 with toggling ready");
        ready_mode = 1;
        apply_cfg(3'b101);
        apply_stimulus(16'hBEEF, 16'h5555, 16'hC0DE, 1, 1);
        wait_idle("mask101");

        $display("[TB] overrun handling");
        apply_cfg(3'b111);
        ready_mode = 3;
        apply_stimulus(16'h1111, 16'h2222, 16'h3333, 1, 0);
        repeat (3) cycle();
        check_output("overrun_pre", 32'(overrun), 32'd0);
        sec = 1'b1;
        cycle();
        sec = 1'b0;
        check_output("overrun_set", 32'(overrun), 32'd1);
        sec = 1'b1;
        overrun_clr = 1'b1;
        cycle();
        sec = 1'b0;
        overrun_clr = 1'b0;
        check_output("overrun_set_wins", 32'(overrun), 32'd1);
        check_output("overrun_frame_busy", 32'(busy), 32'd1);
        ready_mode = 1;
        wait_idle("overrun_frame");
        cycle();
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check_output("overrun_cleared", 32'(overrun), 32'd0);

        $display("[TB] disable channels mid-frame");
        ready_mode = 1;
        apply_stimulus(16'hA0A0, 16'hB0B0, 16'hC0C0, 1, 0);
        apply_cfg(3'b000);
        wait_idle("disable_frame");
        for (int k = 0; k < 3; k++) begin
            sec = 1'b1;
            cycle();
            sec = 1'b0;
            repeat (3) cycle();
            check_output("disabled_busy", 32'(busy), 32'd0);
            check_output("disabled_overrun", 32'(overrun), 32'd0);
        end

        $display("[TB] handshake beats terminal tick");
        apply_cfg(3'b111);
        ready_mode = 4;
        out_ready = 1'b0;
        apply_stimulus(16'h0F0F, 16'hF0F0, 16'h00FF, 1, 0);
        for (int k = 0; k < 2; k++) begin
            msec = 1'b1;
            cycle();
            msec = 1'b0;
            cycle();
        end
        msec = 1'b1;
        out_ready = 1'b1;
        cycle();
        msec = 1'b0;
        ready_mode = 0;
        wait_idle("hs_wins");
        check_output("hs_wins_no_drop", 32'(drop_cnt), sat_drop());

        $display("[TB] consumer timeout");
        ready_mode = 3;
        apply_stimulus(16'h1234, 16'h5678, 16'h9ABC, 0, 0);
        for (tick = 1; tick <= 3; tick++) begin
            repeat (9) cycle();
            check_output("timeout_valid_before_tick", 32'(out_valid), 32'd1);
            msec = 1'b1;
            cycle();
            msec = 1'b0;
        end
        check_output("timeout_valid_dropped", 32'(out_valid), 32'd0);
        model_drop++;
        check_output("timeout_drop1", 32'(drop_cnt), sat_drop());
        cycle();
        for (int f = 0; f < 300; f++) begin
            apply_stimulus(16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
            repeat (3) begin
                msec = 1'b1;
                cycle();
            end
            msec = 1'b0;
            model_drop++;
            check_output("timeout_drop_sat", 32'(drop_cnt), sat_drop());
            cycle();
        end
        check_output("drop_saturated", 32'(drop_cnt), 32'd255);

        $display("[TB] reset mid-frame");
        apply_cfg(3'b011);
        ready_mode = 0;
        apply_stimulus(16'h4444, 16'h5555, 16'h6666, 1, 0);
        cycle();
        reset = 1'b0;
        #1;
        check_output("midrst_valid", 32'(out_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        model_drop  = 0;
        model_ch_en = EN_RST;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        apply_stimulus(16'h7777, 16'h8888, 16'h9999, 1, 1);
        wait_idle("post_reset");

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            en = 3'($urandom_range(0, 7));
            apply_cfg(en);
            ready_mode = $urandom_range(0, 2);
            if (en != 3'b000) begin
                apply_stimulus(16'($urandom), 16'($urandom), 16'($urandom), 1, 1);
                wait_idle("rand");
            end else begin
                sec = 1'b1;
                cycle();
                sec = 1'b0;
                cycle();
                check_output("rand_disabled_busy", 32'(busy), 32'd0);
            end
        end
        check_output("final_overrun", 32'(overrun), 32'd0);
        check_output("final_drop", 32'(drop_cnt), sat_drop());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
